// File: rtl/weight_loader_mux.sv
// Distributes weight words from a weight RAM to NUM_UNITS neuron units, by auto-load FSM or manual writes.
// Optional running checksum of auto-loaded weights: define WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader_mux #(
  parameter int NUM_UNITS        = 6,
  parameter int DATA_W           = 32,
  parameter int WEIGHTS_PER_UNIT = 4,
  parameter int ADDR_W           = 10,
  parameter int BASE_ADDR        = 0,
  localparam int IW = (WEIGHTS_PER_UNIT > 1) ? $clog2(WEIGHTS_PER_UNIT) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              abort,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              man_write,
  input  logic [3:0]        man_sel,
  input  logic [DATA_W-1:0] man_data,
  output logic [DATA_W-1:0] weight_out,
  output logic [IW-1:0]     weight_idx,
  output logic [NUM_UNITS-1:0] write_vec,
  output logic              busy,
  output logic              done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [UW-1:0] LAST_UNIT = UW'(NUM_UNITS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(WEIGHTS_PER_UNIT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state, state_nxt;
  logic [UW-1:0] unit, unit_nxt, pend_unit, pend_unit_nxt;
  logic [IW-1:0] idx, idx_nxt, pend_idx, pend_idx_nxt;
  logic [ADDR_W-1:0] addr_ptr, addr_ptr_nxt, ram_addr_nxt;
  logic pend, pend_nxt;
  logic ram_en_nxt, busy_nxt, done_nxt, aborting, last;
  logic [DATA_W-1:0] weight_out_nxt;
  logic [IW-1:0] weight_idx_nxt;
  logic [NUM_UNITS-1:0] write_vec_nxt;

  assign aborting = abort && (state != IDLE);
  assign last     = (unit == LAST_UNIT) && (idx == LAST_IDX);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      unit       <= '0;
      idx        <= '0;
      addr_ptr   <= '0;
      pend       <= 1'b0;
      pend_unit  <= '0;
      pend_idx   <= '0;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      weight_out <= '0;
      weight_idx <= '0;
      write_vec  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      unit       <= unit_nxt;
      idx        <= idx_nxt;
      addr_ptr   <= addr_ptr_nxt;
      pend       <= pend_nxt;
      pend_unit  <= pend_unit_nxt;
      pend_idx   <= pend_idx_nxt;
      ram_en     <= ram_en_nxt;
      ram_addr   <= ram_addr_nxt;
      weight_out <= weight_out_nxt;
      weight_idx <= weight_idx_nxt;
      write_vec  <= write_vec_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = aborting ? IDLE : WRITE;
      WRITE:   state_nxt = aborting ? IDLE : (last ? DONE : READ);
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM data for a WRITE-state slot arrives one cycle later, so the strobe is issued from the pending record.
  always_comb begin
    unit_nxt       = unit;
    idx_nxt        = idx;
    addr_ptr_nxt   = addr_ptr;
    pend_nxt       = 1'b0;
    pend_unit_nxt  = pend_unit;
    pend_idx_nxt   = pend_idx;
    ram_en_nxt     = 1'b0;
    ram_addr_nxt   = ram_addr;
    weight_out_nxt = weight_out;
    weight_idx_nxt = weight_idx;
    write_vec_nxt  = '0;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    if (pend) begin
      weight_out_nxt = ram_data;
      weight_idx_nxt = pend_idx;
      for (int u = 0; u < NUM_UNITS; u++) write_vec_nxt[u] = (pend_unit == UW'(u));
    end
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt     = 1'b1;
          unit_nxt     = '0;
          idx_nxt      = '0;
          addr_ptr_nxt = ADDR_W'(BASE_ADDR);
        end else if (man_write) begin
          weight_out_nxt = man_data;
          weight_idx_nxt = '0;
          for (int u = 0; u < NUM_UNITS; u++) write_vec_nxt[u] = (man_sel == 4'(u));
        end
      end
      READ: begin
        ram_en_nxt   = 1'b1;
        ram_addr_nxt = addr_ptr;
      end
      WRITE: begin
        pend_nxt      = 1'b1;
        pend_unit_nxt = unit;
        pend_idx_nxt  = idx;
        addr_ptr_nxt  = addr_ptr + 1'b1;
        if (idx == LAST_IDX) begin
          idx_nxt  = '0;
          unit_nxt = (unit == LAST_UNIT) ? '0 : unit + 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      default: ;
    endcase
    if (aborting) begin
      pend_nxt       = 1'b0;
      ram_en_nxt     = 1'b0;
      write_vec_nxt  = '0;
      weight_out_nxt = weight_out;
      weight_idx_nxt = weight_idx;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)                    checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (pend && !aborting)      checksum <= checksum + ram_data;
  end
`endif

endmodule
